// File: rtl/calib_pulse_sequencer.sv
// Purpose  : free-running calibration sync clock plus per-run gating of delayed, width-programmed
//            switcher pulses onto enabled channels, in burst (N pulses) or continuous mode.
// Latency  : SyncClock = internal divider clock through SYNC_DLY registers; SwitcherOn/Busy/Done
//            are registered; SwitcherOn rises Delay cycles after the SyncClock output rise.
// Backpress: none; Start is ignored while a run is active, Stop aborts a run on the next cycle.
//
// Ports
//   Clk, reset_n        : only clock; asynchronous active-low reset
//   HalfPeriod          : sync clock half period minus 1, sampled at every sync clock toggle
//   Start / Stop        : 1-cycle run control pulses
//   Continuous, PulseCount, Delay, OnTime, ChannelEnable : run config, latched on accepted Start
//   SyncClock           : synchronous clock output
//   SwitcherOn          : per-channel switcher drive
//   Busy / Done         : run active / 1-cycle end-of-run pulse
//   PulsesSent          : pulses started in the current or last run
module calib_pulse_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int BURST_W  = 16,
    parameter int SYNC_DLY = 2
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic [CNT_W-1:0]   HalfPeriod,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Continuous,
    input  logic [BURST_W-1:0] PulseCount,
    input  logic [CNT_W-1:0]   Delay,
    input  logic [CNT_W-1:0]   OnTime,
    input  logic [NUM_CH-1:0]  ChannelEnable,
    output logic               SyncClock,
    output logic [NUM_CH-1:0]  SwitcherOn,
    output logic               Busy,
    output logic               Done,
    output logic [BURST_W-1:0] PulsesSent
);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    // ------------------------------------------------------------------
    // Sync clock generator: runs in every state.
    // sclk[0] is the internal divided clock, sclk[SYNC_DLY] the output.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  hp_q;
    logic              hp_vld;
    logic [CNT_W-1:0]  hp_eff;
    logic [SYNC_DLY:0] sclk;
    logic              rise_pre;

    // Until the first toggle there is no sampled half period yet, so the
    // live input paces the first half period out of reset.
    assign hp_eff = hp_vld ? hp_q : HalfPeriod;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            hp_q    <= '0;
            hp_vld  <= 1'b0;
            sclk    <= '0;
        end else begin
            if (div_cnt == hp_eff) begin
                div_cnt <= '0;
                hp_q    <= HalfPeriod;
                hp_vld  <= 1'b1;
                sclk[0] <= ~sclk[0];
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            sclk[SYNC_DLY:1] <= sclk[SYNC_DLY-1:0];
        end
    end

    assign SyncClock = sclk[SYNC_DLY];

    // True on the edge at which the SyncClock output goes high, so the
    // registered SwitcherOn can rise in that same cycle when Delay = 0.
    assign rise_pre = sclk[SYNC_DLY-1] & ~sclk[SYNC_DLY];

    // ------------------------------------------------------------------
    // Latched run configuration and pulse window
    // win_t is the cycle index inside the window as seen after the edge;
    // the window covers indices 0 .. Delay+OnTime-1, high from Delay on.
    // ------------------------------------------------------------------
    logic               cont_q;
    logic [BURST_W-1:0] count_q;
    logic [CNT_W-1:0]   delay_q;
    logic [CNT_W-1:0]   ontime_q;
    logic [NUM_CH-1:0]  en_q;

    logic [CNT_W:0]     win_t;
    logic               win_act;

    logic [CNT_W:0]     win_len;
    logic [CNT_W:0]     t_n;
    logic               act_n;
    logic               more;
    logic               start_pulse;
    logic               burst_end;
    logic [BURST_W-1:0] sent_n;
    logic [NUM_CH-1:0]  sw_n;

    always_comb begin
        win_len     = {1'b0, delay_q} + {1'b0, ontime_q};
        more        = cont_q | (PulsesSent < count_q);
        start_pulse = rise_pre & more;
        t_n         = win_t;
        act_n       = 1'b0;
        sent_n      = PulsesSent;
        if (start_pulse) begin
            // A rise restarts the window even if the previous one is still open.
            t_n    = '0;
            act_n  = (win_len != '0);
            sent_n = PulsesSent + 1'b1;
        end else if (win_act && !rise_pre) begin
            t_n   = win_t + 1'b1;
            act_n = (t_n < win_len);
        end
        // A rise with no pulses left truncates the last window: act_n stays 0.
        burst_end = ~cont_q & (sent_n == count_q) & ~act_n;
        sw_n      = (act_n && (t_n >= {1'b0, delay_q})) ? en_q : '0;
    end

    // ------------------------------------------------------------------
    // Run control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            PulsesSent <= '0;
            SwitcherOn <= '0;
            cont_q     <= 1'b0;
            count_q    <= '0;
            delay_q    <= '0;
            ontime_q   <= '0;
            en_q       <= '0;
            win_t      <= '0;
            win_act    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    SwitcherOn <= '0;
                    if (Start && !Stop) begin
                        cont_q     <= Continuous;
                        count_q    <= PulseCount;
                        delay_q    <= Delay;
                        ontime_q   <= OnTime;
                        en_q       <= ChannelEnable;
                        PulsesSent <= '0;
                        win_t      <= '0;
                        win_act    <= 1'b0;
                        Busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        SwitcherOn <= '0;
                        win_act    <= 1'b0;
                        Busy       <= 1'b0;
                        Done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        win_t      <= t_n;
                        win_act    <= act_n;
                        PulsesSent <= sent_n;
                        SwitcherOn <= sw_n;
                        if (burst_end) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    SwitcherOn <= '0;
                    Busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
